// File: rtl/fft_result_unloader_if.sv
// Result stream from the FFT unloader.
// Carries one complex bin and its index per valid/ready handshake.
interface fft_result_unloader_if #(
    parameter int WIDTH = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_re;
    logic [WIDTH-1:0] out_im;
    logic [3:0]       out_index;
    logic             out_last;

    modport master (
        output out_valid,
        output out_re,
        output out_im,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_re,
        input  out_im,
        input  out_index,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/fft_result_unloader.sv
// Waits out the FFT latency, snapshots all 16 bins in one cycle,
// then streams them in index order over a valid/ready port.
module fft_result_unloader #(
    parameter int LATENCY = 64,
    parameter int WIDTH   = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [16*WIDTH-1:0]   xin,
    input  logic [16*WIDTH-1:0]   yin,
    fft_result_unloader_if.master dn,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun
);
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STREAM
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [3:0]          idx_q, idx_d;
    logic [16*WIDTH-1:0] fre_q, fre_d;
    logic [16*WIDTH-1:0] fim_q, fim_d;

    logic                valid_q, valid_d;
    logic [WIDTH-1:0]    re_q, re_d;
    logic [WIDTH-1:0]    im_q, im_d;
    logic [3:0]          index_q, index_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovr_q, ovr_d;

    logic hs;
    logic cap;

    assign hs  = (state_q == STREAM) && valid_q && dn.out_ready;
    assign cap = (state_q == WAIT) && (cnt_q == 8'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            fre_q   <= '0;
            fim_q   <= '0;
            valid_q <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            fre_q   <= fre_d;
            fim_q   <= fim_d;
            valid_q <= valid_d;
            re_q    <= re_d;
            im_q    <= im_d;
            index_q <= index_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = WAIT;
            WAIT:    if (cnt_q == 8'd0) state_d = STREAM;
            STREAM:  if (hs && idx_q == 4'd15) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        fre_d = fre_q;
        fim_d = fim_q;
        if (state_q == IDLE && start) begin
            cnt_d = 8'(LATENCY - 1);
        end else if (state_q == WAIT && cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
        if (cap) begin
            fre_d = xin;
            fim_d = yin;
            idx_d = 4'd0;
        end else if (hs && idx_q != 4'd15) begin
            idx_d = idx_q + 4'd1;
        end
    end

    // Outputs are precomputed from next state so every output is a flop.
    always_comb begin
        valid_d = (state_d == STREAM);
        busy_d  = (state_d != IDLE);
        done_d  = hs && (idx_q == 4'd15);
        ovr_d   = ovr_q | (start && state_q != IDLE);
        re_d    = re_q;
        im_d    = im_q;
        index_d = index_q;
        last_d  = 1'b0;
        if (state_d == STREAM) begin
            re_d    = fre_d[WIDTH*idx_d +: WIDTH];
            im_d    = fim_d[WIDTH*idx_d +: WIDTH];
            index_d = idx_d;
            last_d  = (idx_d == 4'd15);
        end
    end

    assign dn.out_valid = valid_q;
    assign dn.out_re    = re_q;
    assign dn.out_im    = im_q;
    assign dn.out_index = index_q;
    assign dn.out_last  = last_q;
    assign busy         = busy_q;
    assign frame_done   = done_q;
    assign overrun      = ovr_q;
endmodule
